// File: rtl/load_store_unit.sv
// Data-memory access stage: latches a load/store, runs a req/ack handshake with word-wide memory,
// places store lanes, extracts/extends load lanes, and stalls the core until the access retires.
module load_store_unit #(
  parameter int XLEN           = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic            i_clk,
  input  logic            i_reset,
  input  logic            i_mem_read,
  input  logic            i_mem_write,
  input  logic [2:0]      i_funct3,
  input  logic [XLEN-1:0] i_addr,
  input  logic [XLEN-1:0] i_store_data,
  output logic [XLEN-1:0] o_load_data,
  output logic            o_stall,
  output logic            o_done,
  output logic            o_misaligned,
  output logic            o_timeout,
  output logic            o_dmem_req,
  output logic            o_dmem_we,
  output logic [XLEN-1:0] o_dmem_addr,
  output logic [3:0]      o_dmem_be,
  output logic [XLEN-1:0] o_dmem_wdata,
  input  logic            i_dmem_ack,
  input  logic [XLEN-1:0] i_dmem_rdata
);

  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_DONE,
    S_ERR
  } state_t;

  state_t          r_state;
  logic [CW-1:0]   r_wait_cnt;
  logic            r_is_load;
  logic [2:0]      r_funct3;
  logic [1:0]      r_addr_lo;
  logic [XLEN-1:0] r_load_data;
  logic            r_done;
  logic            r_timeout;
  logic            r_dmem_req;
  logic            r_dmem_we;
  logic [XLEN-1:0] r_dmem_addr;
  logic [3:0]      r_dmem_be;
  logic [XLEN-1:0] r_dmem_wdata;

  logic            w_req_any;
  logic            w_f3_ok;
  logic            w_align_ok;
  logic            w_launch_ok;
  logic [3:0]      w_st_be;
  logic [XLEN-1:0] w_st_wdata;
  logic [7:0]      w_ld_byte;
  logic [15:0]     w_ld_half;
  logic [XLEN-1:0] w_ld_ext;

  assign w_req_any = i_mem_read | i_mem_write;

  // Unsigned loads exist only for reads; a store with funct3 100/101 is rejected.
  always_comb begin
    w_f3_ok = 1'b0;
    case (i_funct3)
      3'b000, 3'b001, 3'b010: w_f3_ok = 1'b1;
      3'b100, 3'b101:         w_f3_ok = i_mem_read;
      default:                w_f3_ok = 1'b0;
    endcase
  end

  always_comb begin
    w_align_ok = 1'b1;
    case (i_funct3[1:0])
      2'b01:   w_align_ok = ~i_addr[0];
      2'b10:   w_align_ok = (i_addr[1:0] == 2'b00);
      default: w_align_ok = 1'b1;
    endcase
  end

  assign w_launch_ok  = (r_state == S_IDLE) && w_req_any && w_f3_ok && w_align_ok;
  assign o_misaligned = (r_state == S_IDLE) && w_req_any && !(w_f3_ok && w_align_ok);
  assign o_stall      = w_launch_ok || (r_state == S_REQ);

  // Stores replicate the datum across the word so the enabled lanes always see it.
  always_comb begin
    w_st_be    = 4'b1111;
    w_st_wdata = i_store_data;
    case (i_funct3[1:0])
      2'b00: begin
        w_st_be    = 4'b0001 << i_addr[1:0];
        w_st_wdata = {4{i_store_data[7:0]}};
      end
      2'b01: begin
        w_st_be    = 4'b0011 << {i_addr[1], 1'b0};
        w_st_wdata = {2{i_store_data[15:0]}};
      end
      default: begin
        w_st_be    = 4'b1111;
        w_st_wdata = i_store_data;
      end
    endcase
  end

  always_comb begin
    w_ld_byte = i_dmem_rdata[7:0];
    case (r_addr_lo)
      2'd0:    w_ld_byte = i_dmem_rdata[7:0];
      2'd1:    w_ld_byte = i_dmem_rdata[15:8];
      2'd2:    w_ld_byte = i_dmem_rdata[23:16];
      default: w_ld_byte = i_dmem_rdata[31:24];
    endcase
    w_ld_half = r_addr_lo[1] ? i_dmem_rdata[31:16] : i_dmem_rdata[15:0];
  end

  always_comb begin
    w_ld_ext = i_dmem_rdata;
    case (r_funct3)
      3'b000:  w_ld_ext = {{(XLEN-8){w_ld_byte[7]}}, w_ld_byte};
      3'b100:  w_ld_ext = {{(XLEN-8){1'b0}}, w_ld_byte};
      3'b001:  w_ld_ext = {{(XLEN-16){w_ld_half[15]}}, w_ld_half};
      3'b101:  w_ld_ext = {{(XLEN-16){1'b0}}, w_ld_half};
      default: w_ld_ext = i_dmem_rdata;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state      <= S_IDLE;
      r_wait_cnt   <= '0;
      r_is_load    <= 1'b0;
      r_funct3     <= 3'b000;
      r_addr_lo    <= 2'b00;
      r_load_data  <= '0;
      r_done       <= 1'b0;
      r_timeout    <= 1'b0;
      r_dmem_req   <= 1'b0;
      r_dmem_we    <= 1'b0;
      r_dmem_addr  <= '0;
      r_dmem_be    <= 4'b0000;
      r_dmem_wdata <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_done    <= 1'b0;
          r_timeout <= 1'b0;
          if (w_launch_ok) begin
            r_state      <= S_REQ;
            r_wait_cnt   <= '0;
            r_is_load    <= i_mem_read;
            r_funct3     <= i_funct3;
            r_addr_lo    <= i_addr[1:0];
            r_dmem_req   <= 1'b1;
            r_dmem_we    <= ~i_mem_read;
            r_dmem_addr  <= {i_addr[XLEN-1:2], 2'b00};
            r_dmem_be    <= i_mem_read ? 4'b0000 : w_st_be;
            r_dmem_wdata <= i_mem_read ? '0 : w_st_wdata;
          end
        end
        S_REQ: begin
          if (i_dmem_ack) begin
            r_state      <= S_DONE;
            r_done       <= 1'b1;
            r_dmem_req   <= 1'b0;
            r_dmem_we    <= 1'b0;
            r_dmem_addr  <= '0;
            r_dmem_be    <= 4'b0000;
            r_dmem_wdata <= '0;
            if (r_is_load) begin
              r_load_data <= w_ld_ext;
            end
          end else if (r_wait_cnt == CW'(TIMEOUT_CYCLES - 1)) begin
            // Abort: load_data keeps its previous value.
            r_state      <= S_ERR;
            r_timeout    <= 1'b1;
            r_dmem_req   <= 1'b0;
            r_dmem_we    <= 1'b0;
            r_dmem_addr  <= '0;
            r_dmem_be    <= 4'b0000;
            r_dmem_wdata <= '0;
          end else begin
            r_wait_cnt <= r_wait_cnt + 1'b1;
          end
        end
        S_DONE, S_ERR: begin
          r_state   <= S_IDLE;
          r_done    <= 1'b0;
          r_timeout <= 1'b0;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign o_load_data  = r_load_data;
  assign o_done       = r_done;
  assign o_timeout    = r_timeout;
  assign o_dmem_req   = r_dmem_req;
  assign o_dmem_we    = r_dmem_we;
  assign o_dmem_addr  = r_dmem_addr;
  assign o_dmem_be    = r_dmem_be;
  assign o_dmem_wdata = r_dmem_wdata;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed and randomized accesses checked against a lane-level reference model.
module tb_load_store_unit;

  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        mem_read = 1'b0;
  logic        mem_write = 1'b0;
  logic [2:0]  funct3 = 3'b000;
  logic [31:0] addr = '0;
  logic [31:0] store_data = '0;
  logic [31:0] load_data;
  logic        stall, done, misaligned, timeout;
  logic        dmem_req, dmem_we;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_wdata;
  logic        dmem_ack = 1'b0;
  logic [31:0] dmem_rdata = '0;

  load_store_unit #(.XLEN(32), .TIMEOUT_CYCLES(TO)) dut (
    .i_clk(clk), .i_reset(reset), .i_mem_read(mem_read), .i_mem_write(mem_write),
    .i_funct3(funct3), .i_addr(addr), .i_store_data(store_data), .o_load_data(load_data),
    .o_stall(stall), .o_done(done), .o_misaligned(misaligned), .o_timeout(timeout),
    .o_dmem_req(dmem_req), .o_dmem_we(dmem_we), .o_dmem_addr(dmem_addr), .o_dmem_be(dmem_be),
    .o_dmem_wdata(dmem_wdata), .i_dmem_ack(dmem_ack), .i_dmem_rdata(dmem_rdata)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass = 0;
  logic [31:0] exp_ld = '0;

  // Observations of one access, filled by drive_access.
  logic        ob_misal, ob_stall_launch, ob_req_launch, ob_stable, ob_we;
  logic [31:0] ob_daddr, ob_wdata, ob_ld;
  logic [3:0]  ob_be;
  int          ob_req_cyc, ob_stall_cyc, ob_done_cnt, ob_to_cnt, ob_evt_at;

  typedef struct {
    bit          legal;
    int          req_cyc, stall_cyc, done_cnt, to_cnt, evt_at;
    logic        we;
    logic [31:0] daddr, wdata, wmask, ld;
    logic [3:0]  be;
  } exp_t;

  typedef struct {
    bit          rd, wr;
    logic [2:0]  f3;
    logic [31:0] a, sd, rdat;
    int          dly;
  } vec_t;

  // Reference model: access size, lane positions and extension from plain arithmetic.
  function automatic exp_t model_access(bit rd, logic [2:0] f3, logic [31:0] a, logic [31:0] sd,
                                        logic [31:0] rdat, int dly, logic [31:0] prev);
    exp_t e;
    int size, lo;
    bit ok;
    logic [31:0] v, mask;
    size = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
    lo = int'(a % 32'd4);
    e.legal = ((f3 inside {3'b000, 3'b001, 3'b010}) || (rd && (f3 inside {3'b100, 3'b101})))
              && (lo % size == 0);
    ok = dly < TO;
    e.req_cyc = !e.legal ? 0 : (ok ? dly + 1 : TO);
    e.stall_cyc = e.legal ? e.req_cyc + 1 : 0;
    e.done_cnt = (e.legal && ok) ? 1 : 0;
    e.to_cnt = (e.legal && !ok) ? 1 : 0;
    e.evt_at = e.legal ? e.req_cyc : -1;
    e.we = !rd;
    e.daddr = a - 32'(lo);
    e.be = 4'b0000;
    e.wdata = '0;
    e.wmask = rd ? 32'h0 : 32'hFFFF_FFFF;
    if (!rd) begin
      for (int i = 0; i < 4; i++) begin
        if (i >= lo && i < lo + size) e.be[i] = 1'b1;
        e.wdata[8*i +: 8] = sd[8*(i % size) +: 8];
      end
    end
    e.ld = prev;
    if (e.legal && ok && rd) begin
      v = rdat >> (8 * lo);
      mask = (size == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * size)) - 32'd1);
      v = v & mask;
      if (!f3[2] && size < 4 && v[8*size-1]) v = v | ~mask;
      e.ld = v;
    end
    return e;
  endfunction

  // Launch one request, scramble the inputs afterwards, ack after dly REQ cycles, watch 20 cycles.
  task automatic drive_access(input bit rd, input bit wr, input logic [2:0] f3, input logic [31:0] a,
                              input logic [31:0] sd, input logic [31:0] rdat, input int dly);
    int reqidx;
    @(negedge clk);
    mem_read = rd; mem_write = wr; funct3 = f3; addr = a; store_data = sd; dmem_ack = 1'b0;
    #1;
    ob_misal = misaligned; ob_stall_launch = stall; ob_req_launch = dmem_req;
    ob_req_cyc = 0; ob_stall_cyc = stall ? 1 : 0; ob_done_cnt = 0; ob_to_cnt = 0;
    ob_evt_at = -1; ob_stable = 1'b1; reqidx = 0;
    @(posedge clk);
    @(negedge clk);
    mem_read = 1'b0; mem_write = 1'b0; addr = $urandom; store_data = $urandom; funct3 = 3'($urandom);
    for (int c = 0; c < 20; c++) begin
      if (dmem_req) begin
        if (ob_req_cyc == 0) begin
          ob_we = dmem_we; ob_daddr = dmem_addr; ob_be = dmem_be; ob_wdata = dmem_wdata;
        end else if ({dmem_we, dmem_addr, dmem_be, dmem_wdata} !== {ob_we, ob_daddr, ob_be, ob_wdata}) begin
          ob_stable = 1'b0;
        end
        ob_req_cyc++;
      end
      if (stall) ob_stall_cyc++;
      if (done) ob_done_cnt++;
      if (timeout) ob_to_cnt++;
      if ((done || timeout) && ob_evt_at < 0) ob_evt_at = c;
      dmem_ack = dmem_req ? (reqidx == dly) : 1'($urandom);
      dmem_rdata = (dmem_req && reqidx == dly) ? rdat : $urandom;
      if (dmem_req) reqidx++;
      @(posedge clk);
      @(negedge clk);
    end
    dmem_ack = 1'b0;
    ob_ld = load_data;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if ({dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata, done, timeout, stall, misaligned} !== '0)
      $display("FAIL reset_outputs: req=%b we=%b addr=%h be=%b wdata=%h done=%b to=%b stall=%b mis=%b, want all 0",
               dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata, done, timeout, stall, misaligned);
    else n_pass++;
    n_checks++;
    if (load_data !== 32'h0) $display("FAIL reset_load_data: got %h want 00000000", load_data);
    else n_pass++;
    reset = 1'b0;
    exp_ld = '0;
  endtask

  task automatic test_directed();
    vec_t dv[$];
    exp_t e;
    dv.push_back('{1, 0, 3'b010, 32'h100, 32'h0, 32'hDEADBEEF, 1});
    dv.push_back('{1, 0, 3'b000, 32'h103, 32'h0, 32'h80112233, 0});
    dv.push_back('{1, 0, 3'b100, 32'h103, 32'h0, 32'h80112233, 0});
    dv.push_back('{1, 0, 3'b001, 32'h102, 32'h0, 32'h80112233, 0});
    dv.push_back('{0, 1, 3'b000, 32'h201, 32'h000000AB, 32'h0, 0});
    dv.push_back('{1, 0, 3'b010, 32'h102, 32'h0, 32'h12345678, 0});
    dv.push_back('{0, 1, 3'b001, 32'h203, 32'h1234, 32'h0, 0});
    dv.push_back('{0, 1, 3'b100, 32'h200, 32'h55, 32'h0, 0});
    dv.push_back('{1, 0, 3'b011, 32'h200, 32'h0, 32'h0, 0});
    dv.push_back('{1, 0, 3'b010, 32'h300, 32'h0, 32'h0, 99});
    dv.push_back('{1, 0, 3'b010, 32'h104, 32'h0, 32'hA5A5C3C3, 2});
    dv.push_back('{1, 1, 3'b101, 32'h106, 32'h77777777, 32'hF00D1234, 1});
    dv.push_back('{0, 1, 3'b010, 32'h20C, 32'h12345678, 32'h0, 3});
    dv.push_back('{0, 1, 3'b001, 32'h202, 32'hCAFEBEEF, 32'h0, 0});
    dv.push_back('{1, 0, 3'b010, 32'h110, 32'h0, 32'h0BADF00D, TO - 1});
    foreach (dv[i]) begin
      e = model_access(dv[i].rd, dv[i].f3, dv[i].a, dv[i].sd, dv[i].rdat, dv[i].dly, exp_ld);
      drive_access(dv[i].rd, dv[i].wr, dv[i].f3, dv[i].a, dv[i].sd, dv[i].rdat, dv[i].dly);
      n_checks++;
      if ({ob_misal, ob_stall_launch, ob_req_launch} !== {!e.legal, e.legal, 1'b0})
        $display("FAIL dir[%0d]_launch: mis/stall/req=%b%b%b want %b%b0", i, ob_misal, ob_stall_launch,
                 ob_req_launch, !e.legal, e.legal);
      else n_pass++;
      n_checks++;
      if (ob_req_cyc != e.req_cyc || ob_stall_cyc != e.stall_cyc || ob_done_cnt != e.done_cnt ||
          ob_to_cnt != e.to_cnt || ob_evt_at != e.evt_at)
        $display("FAIL dir[%0d]_timing: req=%0d stall=%0d done=%0d to=%0d at=%0d want %0d %0d %0d %0d %0d", i,
                 ob_req_cyc, ob_stall_cyc, ob_done_cnt, ob_to_cnt, ob_evt_at,
                 e.req_cyc, e.stall_cyc, e.done_cnt, e.to_cnt, e.evt_at);
      else n_pass++;
      if (e.legal) begin
        n_checks++;
        if ({ob_we, ob_daddr, ob_be, ob_wdata & e.wmask, ob_stable} !== {e.we, e.daddr, e.be, e.wdata & e.wmask, 1'b1})
          $display("FAIL dir[%0d]_bus: we=%b addr=%h be=%b wdata=%h stable=%b want we=%b addr=%h be=%b wdata=%h", i,
                   ob_we, ob_daddr, ob_be, ob_wdata, ob_stable, e.we, e.daddr, e.be, e.wdata & e.wmask);
        else n_pass++;
      end
      n_checks++;
      if (ob_ld !== e.ld) $display("FAIL dir[%0d]_load_data: got %h want %h", i, ob_ld, e.ld);
      else n_pass++;
      exp_ld = e.ld;
    end
  endtask

  task automatic test_reset_mid();
    logic req_before;
    int spurious;
    @(negedge clk);
    mem_read = 1'b1; funct3 = 3'b010; addr = 32'h500;
    @(posedge clk);
    @(negedge clk);
    mem_read = 1'b0;
    @(posedge clk);
    @(negedge clk);
    req_before = dmem_req;
    reset = 1'b1; dmem_ack = 1'b1; dmem_rdata = 32'h13572468;
    @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (req_before !== 1'b1) $display("FAIL rstmid_req_before: got %b want 1", req_before);
    else n_pass++;
    n_checks++;
    if ({dmem_req, stall, done, load_data} !== {3'b000, 32'h0})
      $display("FAIL rstmid_after: req=%b stall=%b done=%b ld=%h want 0 0 0 00000000",
               dmem_req, stall, done, load_data);
    else n_pass++;
    reset = 1'b0; dmem_ack = 1'b0;
    exp_ld = '0;
    spurious = 0;
    repeat (4) begin
      @(negedge clk);
      if (done || timeout || dmem_req) spurious++;
    end
    n_checks++;
    if (spurious != 0) $display("FAIL rstmid_quiet: %0d active cycles after reset, want 0", spurious);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [11:0] done_v, stall_v, exp_done, exp_stall;
    @(negedge clk);
    mem_read = 1'b1; mem_write = 1'b0; funct3 = 3'b010; addr = 32'h400; dmem_ack = 1'b1;
    for (int c = 0; c < 12; c++) begin
      dmem_rdata = $urandom;
      #1;
      done_v[c] = done;
      stall_v[c] = stall;
      exp_done[c] = (c % 3 == 2);
      exp_stall[c] = (c % 3 != 2);
      if (c % 3 == 1) exp_ld = dmem_rdata;
      @(negedge clk);
    end
    mem_read = 1'b0; dmem_ack = 1'b0;
    n_checks++;
    if (done_v !== exp_done) $display("FAIL b2b_done: got %b want %b", done_v, exp_done);
    else n_pass++;
    n_checks++;
    if (stall_v !== exp_stall) $display("FAIL b2b_stall: got %b want %b", stall_v, exp_stall);
    else n_pass++;
    n_checks++;
    if (load_data !== exp_ld) $display("FAIL b2b_load_data: got %h want %h", load_data, exp_ld);
    else n_pass++;
  endtask

  task automatic test_random();
    exp_t e;
    bit rd, wr;
    logic [2:0] f3;
    logic [31:0] a, sd, rdat;
    int dly, kind, pick;
    for (int i = 0; i < 40; i++) begin
      kind = $urandom % 3;
      rd = (kind != 1);
      wr = (kind != 0);
      pick = $urandom % 6;
      case (pick)
        0: f3 = 3'b000;
        1: f3 = 3'b001;
        2: f3 = 3'b010;
        3: f3 = 3'b100;
        4: f3 = 3'b101;
        default: f3 = 3'($urandom);
      endcase
      a = $urandom; sd = $urandom; rdat = $urandom;
      dly = ($urandom % 8 == 0) ? 40 : int'($urandom % 5);
      e = model_access(rd, f3, a, sd, rdat, dly, exp_ld);
      drive_access(rd, wr, f3, a, sd, rdat, dly);
      n_checks++;
      if ({ob_misal, ob_stall_launch, ob_req_launch} !== {!e.legal, e.legal, 1'b0})
        $display("FAIL rnd[%0d]_launch: mis/stall/req=%b%b%b want %b%b0 (f3=%b a=%h rd=%b)", i, ob_misal,
                 ob_stall_launch, ob_req_launch, !e.legal, e.legal, f3, a, rd);
      else n_pass++;
      n_checks++;
      if (ob_req_cyc != e.req_cyc || ob_stall_cyc != e.stall_cyc || ob_done_cnt != e.done_cnt ||
          ob_to_cnt != e.to_cnt || ob_evt_at != e.evt_at)
        $display("FAIL rnd[%0d]_timing: req=%0d stall=%0d done=%0d to=%0d at=%0d want %0d %0d %0d %0d %0d", i,
                 ob_req_cyc, ob_stall_cyc, ob_done_cnt, ob_to_cnt, ob_evt_at,
                 e.req_cyc, e.stall_cyc, e.done_cnt, e.to_cnt, e.evt_at);
      else n_pass++;
      if (e.legal) begin
        n_checks++;
        if ({ob_we, ob_daddr, ob_be, ob_wdata & e.wmask, ob_stable} !== {e.we, e.daddr, e.be, e.wdata & e.wmask, 1'b1})
          $display("FAIL rnd[%0d]_bus: we=%b addr=%h be=%b wdata=%h stable=%b want we=%b addr=%h be=%b wdata=%h", i,
                   ob_we, ob_daddr, ob_be, ob_wdata, ob_stable, e.we, e.daddr, e.be, e.wdata & e.wmask);
        else n_pass++;
      end
      n_checks++;
      if (ob_ld !== e.ld) $display("FAIL rnd[%0d]_load_data: got %h want %h (f3=%b a=%h rdat=%h)", i, ob_ld, e.ld,
                                   f3, a, rdat);
      else n_pass++;
      exp_ld = e.ld;
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
    $display("%0d/%0d checks passed", n_pass, n_checks + 1);
    $fatal(1, "watchdog expired");
  end

endmodule
